seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4; consecutive identical samples needed before a digit is accepted (legal range 2..255).
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: a_to_g  input  8  segment lines, active-high; bit0=a … bit6=g, bit7=dp.
REQ-005 Port: seg_sel  input  4  digit select, active-high one-hot; bit0 is the rightmost digit.
REQ-006 Port: digits  output  16  last complete frame as four BCD nibbles; [3:0] is digit 0.
REQ-007 Port: dp  output  4  decimal-point state per digit for the last complete frame.
REQ-008 Port: digit_err  output  4  per digit, set when the captured pattern is not a legal 0–9 glyph.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when digits, dp and digit_err update.
REQ-010 Port: capturing  output  1  high while the partial-frame mask is non-zero.

Function
REQ-011 Inputs shall pass through a 2-flop synchronizer (both a_to_g and seg_sel); latency to the internal sample is 2 cycles.
REQ-012 FSM states shall be BLANK, SETTLE and HELD.
REQ-013 BLANK: entered when the synchronized seg_sel is not one-hot (0000 or multiple bits set); the stability counter is held at 0.
REQ-014 BLANK→SETTLE: seg_sel becomes one-hot; the counter loads 1 and the {seg_sel, a_to_g} sample is stored.
REQ-015 SETTLE: if the sample equals the stored value, the counter increments; on any difference, the counter reloads 1 and the new sample is stored.
REQ-016 SETTLE→HELD: taken when the counter reaches STABLE_CYCLES. In that same cycle the decoded nibble, dp bit and error bit are written into the shadow slot selected by seg_sel, and the slot's mask bit is set.
REQ-017 HELD: no further write while the sample is unchanged. Any change goes to SETTLE if seg_sel is one-hot, otherwise to BLANK.
REQ-018 Decoding shall be exact on bits [6:0]. Legal patterns:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  Any other pattern gives nibble 4'hF and error=1.
REQ-019 A recapture of a slot whose mask bit is already set shall overwrite that slot; the mask bit is unchanged.
REQ-020 Frame completion: when the mask becomes 4'b1111, all of the following occur in the same cycle:
  - the shadow is copied to digits/dp/digit_err;
  - frame_valid pulses for 1 cycle;
  - the mask clears.
  Outputs therefore update 1 cycle after the fourth slot write.
REQ-021 If a slot write and a mask clear coincide, the write's mask bit shall survive into the next frame.
REQ-022 The counter shall saturate at STABLE_CYCLES and never wrap.

Reset
REQ-023 While reset is high, the following shall hold asynchronously:
  - FSM = BLANK; counter = 0; mask = 0; shadow = 0; synchronizers = 0;
  - outputs: digits=16'h0000, dp=4'h0, digit_err=4'h0, frame_valid=0, capturing=0.
REQ-024 Reset asserted mid-frame shall discard the partial frame. The first frame_valid after release requires four fresh slot captures.

Structure
REQ-025 A shared package (seg_pkg) shall hold:
  - the ten glyph constants;
  - the error nibble 4'hF;
  - the FSM state enumeration.
REQ-026 A combinational sub-module seg7_to_bcd (7-bit pattern in; nibble and error out) shall perform the decode; all sequential logic stays in seg_scan_capture.

Verification
REQ-027 Scan digits 0..3 with 0x06, 0x5B, 0x4F, 0x66 for 8 cycles each (dp=0) -> exactly one frame_valid pulse; digits=16'h4321, digit_err=0.
REQ-028 Same scan with 3-cycle dwell and STABLE_CYCLES=4 -> no frame_valid; capturing stays 0.
REQ-029 Digit 2 driven with 0x49 -> digits[11:8]=4'hF and digit_err=4'b0100; other nibbles decode normally.
REQ-030 Digit 1 glitches for 1 cycle during a 10-cycle dwell (0x3F→0x00→0x3F) -> captured value 0 with no error; frame completes normally.
REQ-031 seg_sel=4'b0011 for 10 cycles -> no slot write. Reset asserted after two slots are captured -> capturing=0 and digits=0; a subsequent full scan yields one frame_valid.
REQ-032 Digit 0 with a_to_g=0xFF (8 with dp) -> digits[3:0]=4'h8, dp[0]=1, digit_err[0]=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan capture block:
// glyph encodings, error nibble, FSM states and a one-hot helper.
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

  localparam logic [3:0] ERR_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Exact seven-segment (bits a..g) to BCD decode; anything that is not
// one of the ten legal glyphs yields the error nibble and err=1.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  // Glyph lookup
  always_comb begin
    nibble = ERR_NIBBLE;
    err    = 1'b1;
    case (pattern)
      GLYPH_0: begin nibble = 4'd0; err = 1'b0; end
      GLYPH_1: begin nibble = 4'd1; err = 1'b0; end
      GLYPH_2: begin nibble = 4'd2; err = 1'b0; end
      GLYPH_3: begin nibble = 4'd3; err = 1'b0; end
      GLYPH_4: begin nibble = 4'd4; err = 1'b0; end
      GLYPH_5: begin nibble = 4'd5; err = 1'b0; end
      GLYPH_6: begin nibble = 4'd6; err = 1'b0; end
      GLYPH_7: begin nibble = 4'd7; err = 1'b0; end
      GLYPH_8: begin nibble = 4'd8; err = 1'b0; end
      GLYPH_9: begin nibble = 4'd9; err = 1'b0; end
      default: begin nibble = ERR_NIBBLE; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed four-digit seven-segment display: debounces each
// digit dwell, decodes it into a shadow frame and publishes complete frames.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  a_to_g,
  input  logic [3:0]  seg_sel,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        capturing
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [7:0]  a_meta_q, a_sync_q;
  logic [3:0]  sel_meta_q, sel_sync_q;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc_s;
  logic [11:0] stored_q, stored_d, sample_s;
  logic [3:0]  mask_q, mask_d, wr_slot_s;
  logic [15:0] shadow_dig_q, shadow_dig_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_err_q, shadow_err_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  err_q, err_d;
  logic        frame_valid_q, frame_valid_d;
  logic        capturing_q, capturing_d;
  logic        wr_s, onehot_s, frame_done_s;
  logic [3:0]  dec_nibble_s;
  logic        dec_err_s;

  seg7_to_bcd u_dec (
    .pattern (a_sync_q[6:0]),
    .nibble  (dec_nibble_s),
    .err     (dec_err_s)
  );

  assign sample_s  = {sel_sync_q, a_sync_q};
  assign onehot_s  = is_onehot4(sel_sync_q);
  assign cnt_inc_s = (cnt_q >= STABLE_W) ? cnt_q : cnt_q + 8'd1;

  // Debounce FSM: a digit is accepted after STABLE_CYCLES identical samples
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stored_d = stored_q;
    wr_s     = 1'b0;
    case (state_q)
      BLANK: begin
        if (onehot_s) begin
          state_d  = SETTLE;
          cnt_d    = 8'd1;
          stored_d = sample_s;
        end else begin
          cnt_d = 8'd0;
        end
      end
      SETTLE, HELD: begin
        if (sample_s == stored_q) begin
          cnt_d = cnt_inc_s;
          if (state_q == SETTLE && cnt_inc_s == STABLE_W) begin
            state_d = HELD;
            wr_s    = 1'b1;
          end else begin
            state_d = state_q;
          end
        end else if (onehot_s) begin
          state_d  = SETTLE;
          cnt_d    = 8'd1;
          stored_d = sample_s;
        end else begin
          state_d = BLANK;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Shadow slot writes and frame publication; a write coinciding with the
  // frame clear keeps its mask bit for the next frame.
  always_comb begin
    frame_done_s = (mask_q == 4'b1111);
    wr_slot_s    = wr_s ? sel_sync_q : 4'd0;
    mask_d       = (frame_done_s ? 4'd0 : mask_q) | wr_slot_s;
    capturing_d  = (mask_d != 4'd0);
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_err_d = shadow_err_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_slot_s[i]) begin
        shadow_dig_d[4*i +: 4] = dec_nibble_s;
        shadow_dp_d[i]         = a_sync_q[7];
        shadow_err_d[i]        = dec_err_s;
      end else begin
        shadow_dig_d[4*i +: 4] = shadow_dig_q[4*i +: 4];
        shadow_dp_d[i]         = shadow_dp_q[i];
        shadow_err_d[i]        = shadow_err_q[i];
      end
    end
    if (frame_done_s) begin
      digits_d      = shadow_dig_q;
      dp_d          = shadow_dp_q;
      err_d         = shadow_err_q;
      frame_valid_d = 1'b1;
    end else begin
      digits_d      = digits_q;
      dp_d          = dp_q;
      err_d         = err_q;
      frame_valid_d = 1'b0;
    end
  end

  // State registers, including the two-stage input synchronizers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_meta_q      <= 8'd0;
      a_sync_q      <= 8'd0;
      sel_meta_q    <= 4'd0;
      sel_sync_q    <= 4'd0;
      state_q       <= BLANK;
      cnt_q         <= 8'd0;
      stored_q      <= 12'd0;
      mask_q        <= 4'd0;
      shadow_dig_q  <= 16'd0;
      shadow_dp_q   <= 4'd0;
      shadow_err_q  <= 4'd0;
      digits_q      <= 16'd0;
      dp_q          <= 4'd0;
      err_q         <= 4'd0;
      frame_valid_q <= 1'b0;
      capturing_q   <= 1'b0;
    end else begin
      a_meta_q      <= a_to_g;
      a_sync_q      <= a_meta_q;
      sel_meta_q    <= seg_sel;
      sel_sync_q    <= sel_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stored_q      <= stored_d;
      mask_q        <= mask_d;
      shadow_dig_q  <= shadow_dig_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_err_q  <= shadow_err_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
      capturing_q   <= capturing_d;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign digit_err   = err_q;
  assign frame_valid = frame_valid_q;
  assign capturing   = capturing_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with hand-computed expectations.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a_to_g;
  logic [3:0]  seg_sel;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        capturing;

  int total = 0;
  int bad = 0;
  int fv_count = 0;
  int cap_count = 0;
  int fv_base;
  int cap_base;

  seg_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_to_g      (a_to_g),
    .seg_sel     (seg_sel),
    .digits      (digits),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .capturing   (capturing)
  );

  always #5 clk = ~clk;

  // Pulse/level monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_count = fv_count + 1;
    if (capturing === 1'b1) cap_count = cap_count + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int cycles);
    seg_sel = sel;
    a_to_g  = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3, input int dwell);
    drive(4'b0001, s0, dwell);
    drive(4'b0010, s1, dwell);
    drive(4'b0100, s2, dwell);
    drive(4'b1000, s3, dwell);
    drive(4'b0000, 8'h00, 8);
  endtask

  task automatic mark();
    @(negedge clk);
    fv_base  = fv_count;
    cap_base = cap_count;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    a_to_g  = 8'h00;
    seg_sel = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digits", digits, 16'h0000);
    check("rst_dp", {12'd0, dp}, 16'h0000);
    check("rst_err", {12'd0, digit_err}, 16'h0000);
    check("rst_fv", {15'd0, frame_valid}, 16'h0000);
    check("rst_cap", {15'd0, capturing}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Short dwell never reaches four stable samples
    mark();
    scan(8'h06, 8'h5B, 8'h4F, 8'h66, 3);
    @(negedge clk);
    check("short_fv", 16'(fv_count - fv_base), 16'd0);
    check("short_cap", 16'(cap_count - cap_base), 16'd0);
    check("short_digits", digits, 16'h0000);

    // Basic scan 1,2,3,4
    mark();
    scan(8'h06, 8'h5B, 8'h4F, 8'h66, 8);
    @(negedge clk);
    check("basic_fv", 16'(fv_count - fv_base), 16'd1);
    check("basic_digits", digits, 16'h4321);
    check("basic_err", {12'd0, digit_err}, 16'h0000);
    check("basic_dp", {12'd0, dp}, 16'h0000);
    check("basic_cap", {15'd0, capturing}, 16'h0000);

    // Illegal glyph on digit 2
    mark();
    scan(8'h06, 8'h5B, 8'h49, 8'h66, 8);
    @(negedge clk);
    check("bad_fv", 16'(fv_count - fv_base), 16'd1);
    check("bad_digits", digits, 16'h4F21);
    check("bad_err", {12'd0, digit_err}, 16'h0004);

    // One-cycle glitch inside a 10-cycle dwell on digit 1
    mark();
    drive(4'b0001, 8'h06, 8);
    drive(4'b0010, 8'h3F, 3);
    drive(4'b0010, 8'h00, 1);
    drive(4'b0010, 8'h3F, 6);
    drive(4'b0100, 8'h5B, 8);
    drive(4'b1000, 8'h4F, 8);
    drive(4'b0000, 8'h00, 8);
    @(negedge clk);
    check("glitch_fv", 16'(fv_count - fv_base), 16'd1);
    check("glitch_digits", digits, 16'h3201);
    check("glitch_err", {12'd0, digit_err}, 16'h0000);

    // Digit 0 shows 8 with decimal point
    mark();
    scan(8'hFF, 8'h06, 8'h06, 8'h06, 8);
    @(negedge clk);
    check("dp8_fv", 16'(fv_count - fv_base), 16'd1);
    check("dp8_digits", digits, 16'h1118);
    check("dp8_dp", {12'd0, dp}, 16'h0001);
    check("dp8_err", {12'd0, digit_err}, 16'h0000);

    // Multi-hot select never writes a slot
    mark();
    drive(4'b0011, 8'h3F, 10);
    drive(4'b0000, 8'h00, 4);
    @(negedge clk);
    check("multihot_cap", 16'(cap_count - cap_base), 16'd0);

    // Reset after two captured slots discards the partial frame
    drive(4'b0001, 8'h06, 8);
    drive(4'b0010, 8'h5B, 8);
    drive(4'b0000, 8'h00, 4);
    @(negedge clk);
    check("partial_cap", {15'd0, capturing}, 16'h0001);
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check("midrst_cap", {15'd0, capturing}, 16'h0000);
    check("midrst_digits", digits, 16'h0000);
    check("midrst_dp", {12'd0, dp}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    mark();
    drive(4'b0100, 8'h5B, 8);
    drive(4'b1000, 8'h06, 8);
    drive(4'b0000, 8'h00, 8);
    @(negedge clk);
    check("postrst_half_fv", 16'(fv_count - fv_base), 16'd0);
    check("postrst_half_cap", {15'd0, capturing}, 16'h0001);
    drive(4'b0001, 8'h66, 8);
    drive(4'b0010, 8'h4F, 8);
    drive(4'b0000, 8'h00, 8);
    @(negedge clk);
    check("postrst_fv", 16'(fv_count - fv_base), 16'd1);
    check("postrst_digits", digits, 16'h1234);
    check("postrst_cap", {15'd0, capturing}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
